// File: rtl/gpu_draw_scheduler.sv
// Draw-instruction FIFO and dispatcher that feeds the shared raster engine.
// It runs a start/done handshake with the engine and reports FIFO full, occupancy and overflow.
module gpu_draw_scheduler #(
  parameter int DEPTH        = 4,
  parameter int WIDTH_BITS   = 10,
  parameter int HEIGHT_BITS  = 9,
  parameter int CHANNEL_BITS = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_i,
  input  logic [3:0]                    opcode_i,
  input  logic [WIDTH_BITS-1:0]         x1_i,
  input  logic [HEIGHT_BITS-1:0]        y1_i,
  input  logic [WIDTH_BITS-1:0]         x2_i,
  input  logic [HEIGHT_BITS-1:0]        y2_i,
  input  logic [WIDTH_BITS-1:0]         rad_i,
  input  logic [2:0]                    oct_i,
  input  logic [CHANNEL_BITS-1:0]       r_i,
  input  logic [CHANNEL_BITS-1:0]       g_i,
  input  logic [CHANNEL_BITS-1:0]       b_i,
  input  logic                          clear_i,
  input  logic                          done_i,
  output logic                          start_o,
  output logic [3:0]                    cmd_opcode_o,
  output logic [WIDTH_BITS-1:0]         cmd_x1_o,
  output logic [HEIGHT_BITS-1:0]        cmd_y1_o,
  output logic [WIDTH_BITS-1:0]         cmd_x2_o,
  output logic [HEIGHT_BITS-1:0]        cmd_y2_o,
  output logic [WIDTH_BITS-1:0]         cmd_rad_o,
  output logic [2:0]                    cmd_oct_o,
  output logic [CHANNEL_BITS-1:0]       cmd_r_o,
  output logic [CHANNEL_BITS-1:0]       cmd_g_o,
  output logic [CHANNEL_BITS-1:0]       cmd_b_o,
  output logic                          busy_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(DEPTH+1)-1:0]    count_o,
  output logic                          overflow_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH+1);
  localparam int ENTRY_W = 4 + 3*WIDTH_BITS + 2*HEIGHT_BITS + 3 + 3*CHANNEL_BITS;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] entry_in;
  logic [ENTRY_W-1:0] cmd_q, cmd_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [0:0]         state_q, state_d;
  logic               start_q, start_d;
  logic               overflow_q, overflow_d;
  logic               empty, full, op_ok, push_ok, pop;

  assign entry_in = {opcode_i, x1_i, y1_i, x2_i, y2_i, rad_i, oct_i, r_i, g_i, b_i};

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == FULL_CNT);
    op_ok   = push_i && (opcode_i[3:2] == 2'b01);
    // In WAIT a pop needs done_i; in IDLE done_i plays no part.
    pop     = !empty && ((state_q == S_IDLE) || done_i);
    push_ok = op_ok && !clear_i && !full;

    state_d    = state_q;
    cmd_d      = cmd_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    start_d    = pop;
    overflow_d = overflow_q | (op_ok && !clear_i && full);

    if (pop) begin
      cmd_d    = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      state_d  = S_WAIT;
    end else if ((state_q == S_WAIT) && done_i) begin
      state_d = S_IDLE;
    end

    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);

    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Flush leaves the FSM and any command being dispatched this cycle alone.
    if (clear_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      start_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      start_q    <= start_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= entry_in;
  end

  assign {cmd_opcode_o, cmd_x1_o, cmd_y1_o, cmd_x2_o, cmd_y2_o, cmd_rad_o,
          cmd_oct_o, cmd_r_o, cmd_g_o, cmd_b_o} = cmd_q;

  assign start_o    = start_q;
  assign busy_o     = (state_q == S_WAIT) || !empty;
  assign full_o     = full;
  assign empty_o    = empty;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_gpu_draw_scheduler.sv
// Directed bench for gpu_draw_scheduler: a queue-based reference model checked every cycle,
// plus literal expectations taken from the intended behaviour.
module tb_gpu_draw_scheduler;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [3:0] op;
    logic [9:0] x1;
    logic [8:0] y1;
    logic [9:0] x2;
    logic [8:0] y2;
    logic [9:0] rad;
    logic [2:0] oct;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push_i = 1'b0, clear_i = 1'b0, done_i = 1'b0;
  logic [3:0] opcode_i = '0;
  logic [9:0] x1_i = '0, x2_i = '0, rad_i = '0;
  logic [8:0] y1_i = '0, y2_i = '0;
  logic [2:0] oct_i = '0;
  logic [7:0] r_i = '0, g_i = '0, b_i = '0;
  logic       start_o, busy_o, full_o, empty_o, overflow_o;
  logic [3:0] cmd_opcode_o;
  logic [9:0] cmd_x1_o, cmd_x2_o, cmd_rad_o;
  logic [8:0] cmd_y1_o, cmd_y2_o;
  logic [2:0] cmd_oct_o;
  logic [7:0] cmd_r_o, cmd_g_o, cmd_b_o;
  logic [2:0] count_o;

  gpu_draw_scheduler #(.DEPTH(DEPTH), .WIDTH_BITS(10), .HEIGHT_BITS(9), .CHANNEL_BITS(8)) dut (
    .clk(clk), .rst(rst), .push_i(push_i), .opcode_i(opcode_i),
    .x1_i(x1_i), .y1_i(y1_i), .x2_i(x2_i), .y2_i(y2_i), .rad_i(rad_i), .oct_i(oct_i),
    .r_i(r_i), .g_i(g_i), .b_i(b_i), .clear_i(clear_i), .done_i(done_i),
    .start_o(start_o), .cmd_opcode_o(cmd_opcode_o), .cmd_x1_o(cmd_x1_o), .cmd_y1_o(cmd_y1_o),
    .cmd_x2_o(cmd_x2_o), .cmd_y2_o(cmd_y2_o), .cmd_rad_o(cmd_rad_o), .cmd_oct_o(cmd_oct_o),
    .cmd_r_o(cmd_r_o), .cmd_g_o(cmd_g_o), .cmd_b_o(cmd_b_o), .busy_o(busy_o),
    .full_o(full_o), .empty_o(empty_o), .count_o(count_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending draws plus an "engine owns a command" flag.
  ent_t m_q[$];
  ent_t m_cur = '0;
  bit   m_busy = 1'b0, m_start = 1'b0, m_ovf = 1'b0;
  bit   m_pop, m_valid, m_was_full;
  ent_t in_ent;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_cur = '0; m_busy = 1'b0; m_start = 1'b0; m_ovf = 1'b0;
    end else begin
      in_ent = '{opcode_i, x1_i, y1_i, x2_i, y2_i, rad_i, oct_i, r_i, g_i, b_i};
      m_valid = push_i && (opcode_i == 4'h4 || opcode_i == 4'h5 ||
                           opcode_i == 4'h6 || opcode_i == 4'h7);
      m_was_full = (m_q.size() == DEPTH);
      m_pop = (m_q.size() != 0) && (!m_busy || done_i);
      if (m_pop) begin
        m_cur = m_q.pop_front();
        m_busy = 1'b1;
      end else if (done_i) begin
        m_busy = 1'b0;
      end
      if (clear_i) begin
        m_q.delete();
        m_ovf = 1'b0;
      end else if (m_valid) begin
        if (m_was_full) m_ovf = 1'b1;
        else m_q.push_back(in_ent);
      end
      m_start = m_pop;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("start_o", start_o, m_start);
      check("cmd", {cmd_opcode_o, cmd_x1_o, cmd_y1_o, cmd_x2_o, cmd_y2_o, cmd_rad_o,
                    cmd_oct_o, cmd_r_o, cmd_g_o, cmd_b_o}, m_cur);
      check("busy_o", busy_o, m_busy || (m_q.size() != 0));
      check("full_o", full_o, m_q.size() == DEPTH);
      check("empty_o", empty_o, m_q.size() == 0);
      check("count_o", count_o, m_q.size());
      check("overflow_o", overflow_o, m_ovf);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic ent_t mk(input logic [3:0] op, input int x1, input int y1, input int x2,
                              input int y2, input int rad, input int oct,
                              input int r, input int g, input int b);
    ent_t e;
    e.op = op; e.x1 = 10'(x1); e.y1 = 9'(y1); e.x2 = 10'(x2); e.y2 = 9'(y2);
    e.rad = 10'(rad); e.oct = 3'(oct); e.r = 8'(r); e.g = 8'(g); e.b = 8'(b);
    return e;
  endfunction

  task automatic drive(input ent_t e);
    {opcode_i, x1_i, y1_i, x2_i, y2_i, rad_i, oct_i, r_i, g_i, b_i} = e;
  endtask

  task automatic push(input ent_t e);
    drive(e);
    push_i = 1'b1;
    step();
    push_i = 1'b0;
  endtask

  task automatic done_pulse();
    done_i = 1'b1;
    step();
    done_i = 1'b0;
  endtask

  initial begin
    step();
    step();
    check("rst_start", start_o, 1'b0);
    check("rst_count", count_o, 3'd0);
    check("rst_empty", empty_o, 1'b1);
    check("rst_busy", busy_o, 1'b0);
    check("rst_cmd_x1", cmd_x1_o, 10'd0);
    chk_en = 1'b1;
    rst = 1'b0;
    step();

    // Single line: one cycle from FIFO write to start_o.
    push(mk(4'h4, 10, 20, 30, 40, 0, 0, 8'hFF, 8'h00, 8'h80));
    check("line_count", count_o, 3'd1);
    check("line_nostart", start_o, 1'b0);
    step();
    check("line_start", start_o, 1'b1);
    check("line_op", cmd_opcode_o, 4'h4);
    check("line_x1", cmd_x1_o, 10'd10);
    check("line_y1", cmd_y1_o, 9'd20);
    check("line_x2", cmd_x2_o, 10'd30);
    check("line_y2", cmd_y2_o, 9'd40);
    check("line_rgb", {cmd_r_o, cmd_g_o, cmd_b_o}, 24'hFF0080);
    step();
    step();
    check("line_hold_start", start_o, 1'b0);
    check("line_busy", busy_o, 1'b1);
    done_pulse();
    check("line_idle_busy", busy_o, 1'b0);

    // Invalid opcodes are dropped silently.
    push(mk(4'h1, 1, 1, 1, 1, 1, 1, 1, 1, 1));
    push(mk(4'hF, 2, 2, 2, 2, 2, 2, 2, 2, 2));
    step();
    check("bad_count", count_o, 3'd0);
    check("bad_ovf", overflow_o, 1'b0);
    check("bad_start", start_o, 1'b0);

    // Six circles with the engine stalled: one in flight, four queued, one dropped.
    for (int i = 1; i <= 6; i++) push(mk(4'h6, 100, 100, 0, 0, i, 0, 1, 2, 3));
    check("circ_count", count_o, 3'd4);
    check("circ_full", full_o, 1'b1);
    check("circ_ovf", overflow_o, 1'b1);
    check("circ_rad1", cmd_rad_o, 10'd1);
    for (int k = 1; k <= 5; k++) begin
      done_pulse();
      if (k < 5) begin
        check("circ_restart", start_o, 1'b1);
        check("circ_rad", cmd_rad_o, 10'(k + 1));
      end
    end
    check("circ_empty", empty_o, 1'b1);
    check("circ_busy", busy_o, 1'b0);
    check("circ_ovf_sticky", overflow_o, 1'b1);

    // done_i coincident with start_o completes that command.
    push(mk(4'h7, 50, 50, 0, 0, 20, 3, 9, 9, 9));
    push(mk(4'h7, 60, 60, 0, 0, 25, 6, 9, 9, 9));
    check("arc_start1", start_o, 1'b1);
    check("arc_oct3", cmd_oct_o, 3'd3);
    done_pulse();
    check("arc_start2", start_o, 1'b1);
    check("arc_oct6", cmd_oct_o, 3'd6);
    step();
    check("arc_single", start_o, 1'b0);
    done_pulse();
    check("arc_idle", busy_o, 1'b0);

    // Flush with a push in the same cycle: queue and overflow cleared, in-flight kept.
    for (int i = 1; i <= 4; i++) push(mk(4'h5, i, i, i + 10, i + 10, 0, 0, 4, 5, 6));
    check("clr_pre_count", count_o, 3'd3);
    drive(mk(4'h6, 77, 77, 0, 0, 7, 0, 0, 0, 0));
    push_i = 1'b1;
    clear_i = 1'b1;
    step();
    push_i = 1'b0;
    clear_i = 1'b0;
    check("clr_count", count_o, 3'd0);
    check("clr_ovf", overflow_o, 1'b0);
    check("clr_busy", busy_o, 1'b1);
    check("clr_cmd_x1", cmd_x1_o, 10'd1);
    step();
    step();
    done_pulse();
    check("clr_idle", busy_o, 1'b0);
    step();
    step();
    check("clr_nostart", start_o, 1'b0);

    // Asynchronous reset while a command is in flight with two queued.
    for (int i = 7; i <= 9; i++) push(mk(4'h4, i, 0, 0, 0, 0, 0, 0, 0, 0));
    check("rst_pre_count", count_o, 3'd2);
    #2;
    rst = 1'b1;
    #1;
    check("arst_start", start_o, 1'b0);
    check("arst_busy", busy_o, 1'b0);
    check("arst_count", count_o, 3'd0);
    check("arst_empty", empty_o, 1'b1);
    check("arst_cmd_x1", cmd_x1_o, 10'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("post_rst_start", start_o, 1'b0);
    check("post_rst_busy", busy_o, 1'b0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
